cluster_packer_iterative: RTL and testbench
===========================================

Name: cluster_packer_iterative

Overview:
- Parametrised, sequential successor to the fixed 24-VFAT cluster packer.
- Latches one bunch-crossing frame of S-bits and extracts clusters iteratively, one per clock4x cycle, lowest strip address first.
- Each cluster is encoded as address plus size; the block writes up to NUM_CLUSTERS words and flags overflow.
- Supports VFAT2 (8 S-bits/VFAT, sparse strip mapping) and VFAT3 (full-granularity) input modes; sits between the S-bit deserialisers and the trigger link formatter.

Parameters:
- NUM_VFATS, 24, VFATs per chamber.
- SBITS_PER_VFAT, 64, strips per VFAT in the internal strip map.
- VFAT_V2, 0, 1 = input is 8 bits/VFAT, bit i of a VFAT maps to strip 8*i of that VFAT; 0 = input is SBITS_PER_VFAT bits/VFAT, 1:1.
- NUM_CLUSTERS, 8, output cluster slots.
- ADDR_BITS, 11, strip address width; requires NUM_VFATS*SBITS_PER_VFAT <= 2^ADDR_BITS-1.
- SIZE_BITS, 3, size field width; MAX_SIZE = 2^SIZE_BITS strips.

Ports:
- clock4x, in, 1, single clock.
- global_reset, in, 1, asynchronous, active-high reset.
- sbits_i, in, NUM_VFATS*(VFAT_V2 ? 8 : SBITS_PER_VFAT), S-bits, VFAT0 in LSBs.
- frame_valid_i, in, 1, sbits_i valid this cycle; start of frame.
- truncate_clusters, in, 1, sampled with the frame: 1 = discard strips of a run beyond MAX_SIZE.
- clusters_o, out, NUM_CLUSTERS*(ADDR_BITS+SIZE_BITS), slot k at bits [k*W +: W]; word = {size, address}.
- clusters_valid_o, out, 1, one-cycle pulse when clusters_o and overflow_o update.
- overflow_o, out, 1, strips remained after all slots filled.
- busy_o, out, 1, high in SCAN and DONE.
- frame_dropped_o, out, 1, one-cycle pulse when frame_valid_i arrives while busy.

Behaviour:
- Reset values (global_reset asynchronous, takes effect immediately):
  - state = IDLE.
  - Every slot = invalid word: size 0, address all-ones (14'h07FF at defaults).
  - clusters_valid_o, overflow_o, busy_o, frame_dropped_o = 0.
- Reset mid-SCAN aborts the frame: no valid pulse, partial results are discarded.
- FSM IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - On frame_valid_i, load the working register with the strip-mapped S-bits (in VFAT_V2 mode, unmapped strips = 0).
  - Latch truncate_clusters; clear the slot index k and the staging slots to invalid; go to SCAN.
- SCAN, one cluster per cycle:
  - a = lowest set strip.
  - run = consecutive set strips from a, stopping at the first 0, at a VFAT boundary (strip index a multiple of SBITS_PER_VFAT), or at MAX_SIZE strips.
  - Stage {run-1, a} into slot k; clear those run strips; k++.
  - If truncate is latched and the run stopped at MAX_SIZE, also clear the remaining contiguous strips of that run within the same VFAT.
  - With truncate = 0, those remaining strips form a new cluster on a later cycle.
- SCAN exit: go to DONE when the working register becomes empty, or when k reaches NUM_CLUSTERS.
  - Latched overflow = 1 iff strips remain at the moment k reaches NUM_CLUSTERS.
  - An empty frame spends one SCAN cycle, finds nothing, then goes to DONE.
- DONE:
  - Register the staging slots to clusters_o and overflow to overflow_o.
  - Pulse clusters_valid_o for one cycle; return to IDLE.
- Latency from frame_valid_i edge to clusters_valid_o high: max(m,1)+1 edges, where m = clusters found.
  - Worst case is NUM_CLUSTERS+1.
  - A back-to-back frame is accepted in the cycle after the pulse.
- Outputs hold their values until the next DONE.
- frame_valid_i while busy_o = 1:
  - The frame is ignored; frame_dropped_o pulses.
  - The current frame completes unaffected.
- Unused slots are always the invalid word. Slots are in ascending address order.

Test Plan:
- Reset, then an empty frame: all slots 0x07FF, overflow 0, clusters_valid_o pulses 2 edges after frame_valid_i.
- Single hit on strip 100: slot0 = 0x0064, slots1-7 = 0x07FF, latency 2.
- Strips 200-211 hit, truncate 0: slot0 = 0x38C8 (addr 200, size 7), slot1 = 0x18D0 (addr 208, size 3). Same frame with truncate 1: slot0 = 0x38C8, slot1 = 0x07FF.
- Strips 62-65 hit (crosses the VFAT0/VFAT1 boundary): slot0 = 0x083E, slot1 = 0x0840. Ten isolated hits at strips 0,2,...,18: slots hold strips 0-14, overflow_o = 1, latency 9.
- VFAT_V2=1, vfat0 bits 0 and 1 plus vfat1 bit 3 set: slots = 0x0000, 0x0008, 0x0058 (strip 64+24), no merging of the adjacent V2 bits.
- frame_valid_i asserted during SCAN: frame_dropped_o pulses, first-frame results are correct. global_reset mid-SCAN: no valid pulse, all slots 0x07FF, next frame is processed normally.

Source files
------------

// File: rtl/cluster_packer_iterative_if.sv
// Frame/cluster bus of the iterative cluster packer: S-bit frame towards the packer,
// packed cluster words and status back towards the trigger link formatter.
interface cluster_packer_iterative_if #(
   parameter int NUM_VFATS      = 24,
   parameter int SBITS_PER_VFAT = 64,
   parameter int VFAT_V2        = 0,
   parameter int NUM_CLUSTERS   = 8,
   parameter int ADDR_BITS      = 11,
   parameter int SIZE_BITS      = 3
);
   localparam int IN_BITS  = NUM_VFATS * ((VFAT_V2 != 0) ? 8 : SBITS_PER_VFAT);
   localparam int OUT_BITS = NUM_CLUSTERS * (ADDR_BITS + SIZE_BITS);

   logic [IN_BITS-1:0]  sbits_i;
   logic                frame_valid_i;
   logic                truncate_clusters;
   logic [OUT_BITS-1:0] clusters_o;
   logic                clusters_valid_o;
   logic                overflow_o;
   logic                busy_o;
   logic                frame_dropped_o;

   modport master (
      output sbits_i, frame_valid_i, truncate_clusters,
      input  clusters_o, clusters_valid_o, overflow_o, busy_o, frame_dropped_o
   );

   modport slave (
      input  sbits_i, frame_valid_i, truncate_clusters,
      output clusters_o, clusters_valid_o, overflow_o, busy_o, frame_dropped_o
   );
endinterface

// File: rtl/cluster_packer_iterative.sv
// Iterative cluster packer: latches one S-bit frame and peels off one cluster per clock,
// lowest strip first, writing {size-1, address} words into NUM_CLUSTERS slots.
module cluster_packer_iterative #(
   parameter int NUM_VFATS      = 24,
   parameter int SBITS_PER_VFAT = 64,
   parameter int VFAT_V2        = 0,
   parameter int NUM_CLUSTERS   = 8,
   parameter int ADDR_BITS      = 11,
   parameter int SIZE_BITS      = 3
) (
   input logic                      clock4x,
   input logic                      global_reset,
   cluster_packer_iterative_if.slave bus
);
   localparam int W        = ADDR_BITS + SIZE_BITS;
   localparam int NSTRIPS  = NUM_VFATS * SBITS_PER_VFAT;
   localparam int OUT_BITS = NUM_CLUSTERS * W;
   localparam int MAX_SIZE = 1 << SIZE_BITS;
   localparam int K_W      = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
   localparam logic [W-1:0] INVALID_WORD = {{SIZE_BITS{1'b0}}, {ADDR_BITS{1'b1}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    state_r;
   logic [NSTRIPS-1:0]        work_r;
   logic                      trunc_r;
   logic [K_W-1:0]            k_r;
   logic [W-1:0]              stage_r [NUM_CLUSTERS];
   logic                      ovf_stage_r;
   logic [OUT_BITS-1:0]       clusters_r;
   logic                      valid_r;
   logic                      overflow_r;
   logic                      busy_r;
   logic                      dropped_r;

   logic [NSTRIPS-1:0]        mapped_s;
   logic [ADDR_BITS-1:0]      lowest_s;
   logic                      any_s;
   logic [SBITS_PER_VFAT-1:0] win_s;
   logic [SBITS_PER_VFAT-1:0] clr_win_s;
   logic [NSTRIPS-1:0]        clr_s;
   logic [NSTRIPS-1:0]        next_work_s;
   logic                      alive_s;
   int                        a_off_s;
   int                        run_s;
   logic [W-1:0]              word_s;

   generate
      if (VFAT_V2 != 0) begin : g_v2
         // Spread the 8 V2 S-bits of each VFAT onto every eighth strip of its strip map
         always_comb begin
            mapped_s = '0;
            for (int v = 0; v < NUM_VFATS; v++) begin
               for (int i = 0; i < 8; i++) begin
                  mapped_s[v*SBITS_PER_VFAT + 8*i] = bus.sbits_i[v*8 + i];
               end
            end
         end
      end else begin : g_v3
         assign mapped_s = bus.sbits_i;
      end
   endgenerate

   // Priority encoder: lowest set strip of the working register
   always_comb begin
      lowest_s = '0;
      for (int i = NSTRIPS - 1; i >= 0; i--) begin
         lowest_s = work_r[i] ? ADDR_BITS'(i) : lowest_s;
      end
      any_s = |work_r;
   end

   // Measure the run starting at the lowest strip and build the mask of strips it consumes
   always_comb begin
      win_s     = SBITS_PER_VFAT'(work_r >> lowest_s);
      a_off_s   = int'(lowest_s) % SBITS_PER_VFAT;
      alive_s   = 1'b1;
      run_s     = 0;
      clr_win_s = '0;
      for (int j = 0; j < SBITS_PER_VFAT; j++) begin
         // The window ends at the VFAT boundary, so a run never spans two VFATs
         alive_s = alive_s && win_s[j] && (j < SBITS_PER_VFAT - a_off_s);
         if (alive_s) begin
            if (j < MAX_SIZE) begin
               run_s        = run_s + 1;
               clr_win_s[j] = 1'b1;
            end else begin
               clr_win_s[j] = trunc_r;
            end
         end else begin
            clr_win_s[j] = 1'b0;
         end
      end
      clr_s       = {{(NSTRIPS-SBITS_PER_VFAT){1'b0}}, clr_win_s} << lowest_s;
      next_work_s = work_r & ~clr_s;
      word_s      = {SIZE_BITS'(run_s - 1), lowest_s};
   end

   // Frame FSM: latch, iterate one cluster per cycle, publish results
   always_ff @(posedge clock4x or posedge global_reset) begin
      if (global_reset) begin
         state_r     <= IDLE;
         work_r      <= '0;
         trunc_r     <= 1'b0;
         k_r         <= '0;
         ovf_stage_r <= 1'b0;
         for (int k = 0; k < NUM_CLUSTERS; k++) begin
            stage_r[k] <= INVALID_WORD;
         end
         clusters_r  <= {NUM_CLUSTERS{INVALID_WORD}};
         valid_r     <= 1'b0;
         overflow_r  <= 1'b0;
         busy_r      <= 1'b0;
         dropped_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               valid_r   <= 1'b0;
               dropped_r <= 1'b0;
               if (bus.frame_valid_i) begin
                  work_r      <= mapped_s;
                  trunc_r     <= bus.truncate_clusters;
                  k_r         <= '0;
                  ovf_stage_r <= 1'b0;
                  for (int k = 0; k < NUM_CLUSTERS; k++) begin
                     stage_r[k] <= INVALID_WORD;
                  end
                  busy_r      <= 1'b1;
                  state_r     <= SCAN;
               end else begin
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            SCAN: begin
               valid_r   <= 1'b0;
               dropped_r <= bus.frame_valid_i;
               if (!any_s) begin
                  state_r <= DONE;
               end else begin
                  stage_r[k_r] <= word_s;
                  work_r       <= next_work_s;
                  if (k_r == K_W'(NUM_CLUSTERS - 1)) begin
                     ovf_stage_r <= |next_work_s;
                     state_r     <= DONE;
                  end else begin
                     k_r     <= k_r + K_W'(1);
                     state_r <= (|next_work_s) ? SCAN : DONE;
                  end
               end
            end
            DONE: begin
               for (int k = 0; k < NUM_CLUSTERS; k++) begin
                  clusters_r[k*W +: W] <= stage_r[k];
               end
               overflow_r <= ovf_stage_r;
               valid_r    <= 1'b1;
               busy_r     <= 1'b0;
               dropped_r  <= bus.frame_valid_i;
               state_r    <= IDLE;
            end
            default: begin
               valid_r   <= 1'b0;
               busy_r    <= 1'b0;
               dropped_r <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign bus.clusters_o       = clusters_r;
   assign bus.clusters_valid_o = valid_r;
   assign bus.overflow_o       = overflow_r;
   assign bus.busy_o           = busy_r;
   assign bus.frame_dropped_o  = dropped_r;
endmodule

// File: tb/tb_cluster_packer_iterative.sv
// Directed bench for cluster_packer_iterative: default VFAT3 instance plus a VFAT_V2 instance.
module tb_cluster_packer_iterative;
   localparam logic [111:0] ALL_INV = {8{14'h07FF}};

   logic clock4x = 1'b0;
   logic global_reset;
   int   checks = 0;
   int   errors = 0;

   cluster_packer_iterative_if #(.VFAT_V2(0)) bus ();
   cluster_packer_iterative_if #(.VFAT_V2(1)) bus_v2 ();

   cluster_packer_iterative #(.VFAT_V2(0)) dut (
      .clock4x      (clock4x),
      .global_reset (global_reset),
      .bus          (bus)
   );

   cluster_packer_iterative #(.VFAT_V2(1)) dut_v2 (
      .clock4x      (clock4x),
      .global_reset (global_reset),
      .bus          (bus_v2)
   );

   always #5 clock4x = ~clock4x;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [1535:0] strips(input int lo, input int hi, input int step);
      logic [1535:0] s;
      s = '0;
      for (int i = lo; i <= hi; i += step) s[i] = 1'b1;
      return s;
   endfunction

   task automatic start_frame(input logic [1535:0] s, input logic tr);
      @(negedge clock4x);
      bus.sbits_i           = s;
      bus.truncate_clusters = tr;
      bus.frame_valid_i     = 1'b1;
      @(posedge clock4x);
      #1;
      bus.frame_valid_i     = 1'b0;
   endtask

   // lat = edge count after the accepting edge at which clusters_valid_o is seen; 0 on timeout
   task automatic wait_valid(input int start, output int lat);
      int n;
      n   = start;
      lat = 0;
      while (lat == 0 && n < 20) begin
         @(posedge clock4x);
         #1;
         n++;
         if (bus.clusters_valid_o) lat = n;
      end
   endtask

   initial begin
      int            lat;
      int            pulses;
      logic [191:0]  v2s;

      global_reset             = 1'b1;
      bus.sbits_i              = '0;
      bus.frame_valid_i        = 1'b0;
      bus.truncate_clusters    = 1'b0;
      bus_v2.sbits_i           = '0;
      bus_v2.frame_valid_i     = 1'b0;
      bus_v2.truncate_clusters = 1'b0;

      repeat (2) @(posedge clock4x);
      #1;
      check("rst_slots",   bus.clusters_o, ALL_INV);
      check("rst_valid",   bus.clusters_valid_o, 1'b0);
      check("rst_ovf",     bus.overflow_o, 1'b0);
      check("rst_busy",    bus.busy_o, 1'b0);
      check("rst_dropped", bus.frame_dropped_o, 1'b0);
      @(negedge clock4x);
      global_reset = 1'b0;

      // Empty frame
      start_frame('0, 1'b0);
      check("empty_busy", bus.busy_o, 1'b1);
      wait_valid(0, lat);
      check("empty_lat",   lat, 2);
      check("empty_slots", bus.clusters_o, ALL_INV);
      check("empty_ovf",   bus.overflow_o, 1'b0);
      check("empty_idle",  bus.busy_o, 1'b0);

      // Single hit on strip 100
      start_frame(strips(100, 100, 1), 1'b0);
      check("pulse_once", bus.clusters_valid_o, 1'b0);
      wait_valid(0, lat);
      check("s100_lat",   lat, 2);
      check("s100_slots", bus.clusters_o, {{7{14'h07FF}}, 14'h0064});

      // Strips 200-211, no truncation: run split into 8 + 4
      start_frame(strips(200, 211, 1), 1'b0);
      wait_valid(0, lat);
      check("run12_lat",   lat, 3);
      check("run12_slots", bus.clusters_o, {{6{14'h07FF}}, 14'h18D0, 14'h38C8});

      // Same frame with truncation: tail discarded
      start_frame(strips(200, 211, 1), 1'b1);
      wait_valid(0, lat);
      check("trunc_lat",   lat, 2);
      check("trunc_slots", bus.clusters_o, {{7{14'h07FF}}, 14'h38C8});

      // Strips 62-65 straddle the VFAT0/VFAT1 boundary
      start_frame(strips(62, 65, 1), 1'b0);
      wait_valid(0, lat);
      check("vbound_lat",   lat, 3);
      check("vbound_slots", bus.clusters_o, {{6{14'h07FF}}, 14'h0840, 14'h083E});

      // Ten isolated hits: slots fill, overflow flagged
      start_frame(strips(0, 18, 2), 1'b0);
      wait_valid(0, lat);
      check("ovf_lat",   lat, 9);
      check("ovf_flag",  bus.overflow_o, 1'b1);
      check("ovf_slots", bus.clusters_o, {14'h000E, 14'h000C, 14'h000A, 14'h0008,
                                          14'h0006, 14'h0004, 14'h0002, 14'h0000});

      // Exactly eight hits: slots full, nothing left over
      start_frame(strips(0, 14, 2), 1'b0);
      wait_valid(0, lat);
      check("full_lat",   lat, 9);
      check("full_ovf",   bus.overflow_o, 1'b0);
      check("full_slots", bus.clusters_o, {14'h000E, 14'h000C, 14'h000A, 14'h0008,
                                           14'h0006, 14'h0004, 14'h0002, 14'h0000});

      // Frame offered during SCAN is dropped, first frame unaffected
      start_frame(strips(0, 4, 2), 1'b0);
      @(negedge clock4x);
      bus.sbits_i       = strips(500, 500, 1);
      bus.frame_valid_i = 1'b1;
      @(posedge clock4x);
      #1;
      bus.frame_valid_i = 1'b0;
      check("drop_pulse", bus.frame_dropped_o, 1'b1);
      check("drop_busy",  bus.busy_o, 1'b1);
      wait_valid(1, lat);
      check("drop_lat",   lat, 4);
      check("drop_clear", bus.frame_dropped_o, 1'b0);
      check("drop_slots", bus.clusters_o, {{5{14'h07FF}}, 14'h0004, 14'h0002, 14'h0000});

      // VFAT_V2 mapping: adjacent V2 bits land 8 strips apart and stay separate
      v2s     = '0;
      v2s[0]  = 1'b1;
      v2s[1]  = 1'b1;
      v2s[11] = 1'b1;
      @(negedge clock4x);
      bus_v2.sbits_i       = v2s;
      bus_v2.frame_valid_i = 1'b1;
      @(posedge clock4x);
      #1;
      bus_v2.frame_valid_i = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clock4x);
         #1;
         if (lat == 0 && bus_v2.clusters_valid_o) lat = n;
      end
      check("v2_lat",   lat, 4);
      check("v2_slots", bus_v2.clusters_o, {{5{14'h07FF}}, 14'h0058, 14'h0008, 14'h0000});

      // Reset mid-SCAN discards the frame
      start_frame(strips(0, 18, 2), 1'b0);
      repeat (2) @(posedge clock4x);
      @(negedge clock4x);
      global_reset = 1'b1;
      #1;
      check("mrst_slots", bus.clusters_o, ALL_INV);
      check("mrst_busy",  bus.busy_o, 1'b0);
      check("mrst_valid", bus.clusters_valid_o, 1'b0);
      @(negedge clock4x);
      global_reset = 1'b0;
      pulses = 0;
      repeat (12) begin
         @(posedge clock4x);
         #1;
         if (bus.clusters_valid_o) pulses++;
      end
      check("mrst_nopulse", pulses, 0);
      start_frame(strips(100, 100, 1), 1'b0);
      wait_valid(0, lat);
      check("post_rst_lat",   lat, 2);
      check("post_rst_slots", bus.clusters_o, {{7{14'h07FF}}, 14'h0064});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
